// File: rtl/regfile_pkg.sv
// Shared helpers for the multi-port register file: address width and
// highest-index write-port priority selection (up to 32 write ports).
package regfile_pkg;

    localparam int MAX_WPORTS = 32;

    function automatic int addr_w(input int n);
        int a;
        a = $clog2(n);
        return (a < 1) ? 1 : a;
    endfunction

    // One-hot of the highest set bit; zero when no bit is set.
    function automatic logic [31:0] hi_onehot(input logic [31:0] v);
        logic [31:0] r;
        r = 32'h0000_0000;
        for (int i = 0; i < MAX_WPORTS; i++) begin
            r = v[i] ? (32'h0000_0001 << i) : r;
        end
        return r;
    endfunction

    function automatic logic multi_hit(input logic [31:0] v);
        return (v & (v - 32'h0000_0001)) != 32'h0000_0000;
    endfunction

endpackage

// File: rtl/register_en_sync_rst.sv
// Single storage register with load enable and synchronous active-high reset
// to a parameterised value.
module register_en_sync_rst #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Storage flop: reset value, load on enable, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= RST_VAL;
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/regfile_mport_sync_rst.sv
// Multi-port register file with registered reads, highest-port-wins writes,
// collision / out-of-range flags. Define REGFILE_MPORT_BYPASS_EN for write-through reads.
module regfile_mport_sync_rst
    import regfile_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               N_REG     = 32,
    parameter int               N_RPORTS  = 2,
    parameter int               N_WPORTS  = 1,
    parameter int               ZERO_REG0 = 0,
    parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b0}}
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [N_RPORTS-1:0]                      ren,
    input  logic [N_RPORTS-1:0][addr_w(N_REG)-1:0]   raddr,
    output logic [N_RPORTS-1:0]                      rvalid,
    output logic [N_RPORTS-1:0][WIDTH-1:0]           rdata,
    input  logic [N_WPORTS-1:0]                      wen,
    input  logic [N_WPORTS-1:0][addr_w(N_REG)-1:0]   waddr,
    input  logic [N_WPORTS-1:0][WIDTH-1:0]           wdata,
    output logic                                     wr_collision,
    output logic                                     wr_oob
);

    localparam int AW = addr_w(N_REG);

    logic [WIDTH-1:0]              reg_q_s  [N_REG];
    logic [31:0]                   wr_hit_s [N_REG];
    logic [WIDTH-1:0]              wr_din_s [N_REG];
    logic [N_REG-1:0]              wr_en_s;
    logic                          wr_coll_s;
    logic                          wr_oob_s;
    logic                          rd_oob_any_s;
    logic [WIDTH-1:0]              rd_val_s [N_RPORTS];
    logic [N_RPORTS-1:0]           rvalid_r;
    logic [N_RPORTS-1:0][WIDTH-1:0] rdata_r;
    logic                          wr_collision_r;
    logic                          wr_oob_r;

    // Per-register write hits, winning write data and collision / range detect
    always_comb begin
        logic [31:0] sel_v;
        sel_v     = 32'h0000_0000;
        wr_coll_s = 1'b0;
        wr_oob_s  = 1'b0;
        for (int k = 0; k < N_REG; k++) begin
            wr_hit_s[k] = 32'h0000_0000;
            for (int p = 0; p < N_WPORTS; p++) begin
                wr_hit_s[k][p] = wen[p] && (int'(waddr[p]) == k);
            end
            wr_en_s[k]  = |wr_hit_s[k];
            sel_v       = hi_onehot(wr_hit_s[k]);
            wr_din_s[k] = {WIDTH{1'b0}};
            for (int p = 0; p < N_WPORTS; p++) begin
                wr_din_s[k] = wr_din_s[k] | ({WIDTH{sel_v[p]}} & wdata[p]);
            end
            wr_coll_s = wr_coll_s | multi_hit(wr_hit_s[k]);
        end
        for (int p = 0; p < N_WPORTS; p++) begin
            wr_oob_s = wr_oob_s | (wen[p] && (int'(waddr[p]) >= N_REG));
        end
    end

    // Register 0 is a constant when hard-wired to zero; its write hits go nowhere.
    for (genvar k = 0; k < N_REG; k++) begin : g_reg
        if ((ZERO_REG0 != 0) && (k == 0)) begin : g_zero
            assign reg_q_s[k] = {WIDTH{1'b0}};
        end else begin : g_ff
            register_en_sync_rst #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_reg (
                .clk (clk),
                .rst (rst),
                .en  (wr_en_s[k]),
                .d   (wr_din_s[k]),
                .q   (reg_q_s[k])
            );
        end
    end

    // Read mux per port with out-of-range zeroing and optional write-through
    always_comb begin
        logic             addr_oob_v;
`ifdef REGFILE_MPORT_BYPASS_EN
        logic [31:0]      byp_hit_v;
        logic [31:0]      byp_sel_v;
        logic [WIDTH-1:0] byp_data_v;
        logic             zero_v;
        byp_hit_v  = 32'h0000_0000;
        byp_sel_v  = 32'h0000_0000;
        byp_data_v = {WIDTH{1'b0}};
        zero_v     = 1'b0;
`endif
        addr_oob_v   = 1'b0;
        rd_oob_any_s = 1'b0;
        for (int j = 0; j < N_RPORTS; j++) begin
            addr_oob_v = int'(raddr[j]) >= N_REG;
`ifdef REGFILE_MPORT_BYPASS_EN
            byp_hit_v = 32'h0000_0000;
            for (int p = 0; p < N_WPORTS; p++) begin
                byp_hit_v[p] = wen[p] && (waddr[p] == raddr[j]);
            end
            byp_sel_v  = hi_onehot(byp_hit_v);
            byp_data_v = {WIDTH{1'b0}};
            for (int p = 0; p < N_WPORTS; p++) begin
                byp_data_v = byp_data_v | ({WIDTH{byp_sel_v[p]}} & wdata[p]);
            end
            zero_v      = (ZERO_REG0 != 0) && (raddr[j] == {AW{1'b0}});
            rd_val_s[j] = (addr_oob_v || zero_v) ? {WIDTH{1'b0}} :
                          (|byp_hit_v)           ? byp_data_v     : reg_q_s[raddr[j]];
`else
            rd_val_s[j] = addr_oob_v ? {WIDTH{1'b0}} : reg_q_s[raddr[j]];
`endif
            rd_oob_any_s = rd_oob_any_s | (ren[j] && addr_oob_v);
        end
    end

    // Read pipeline stage and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_r       <= {N_RPORTS{1'b0}};
            rdata_r        <= {(N_RPORTS*WIDTH){1'b0}};
            wr_collision_r <= 1'b0;
            wr_oob_r       <= 1'b0;
        end else begin
            for (int j = 0; j < N_RPORTS; j++) begin
                rvalid_r[j] <= ren[j];
                rdata_r[j]  <= ren[j] ? rd_val_s[j] : rdata_r[j];
            end
            wr_collision_r <= wr_coll_s;
            wr_oob_r       <= wr_oob_s | rd_oob_any_s;
        end
    end

    assign rvalid       = rvalid_r;
    assign rdata        = rdata_r;
    assign wr_collision = wr_collision_r;
    assign wr_oob       = wr_oob_r;

endmodule

// File: tb/tb_regfile_mport_sync_rst.sv
// Directed table-driven bench: 20 registers, 2 read / 2 write ports, register 0
// hard-wired to zero, reset value A5A5_A5A5.
module tb_regfile_mport_sync_rst;

    localparam logic [31:0] RV = 32'hA5A5_A5A5;
`ifdef REGFILE_MPORT_BYPASS_EN
    localparam logic [31:0] BYP = 32'h0000_BEEF;
`else
    localparam logic [31:0] BYP = 32'h0000_0000;
`endif

    logic              clk;
    logic              rst;
    logic [1:0]        ren;
    logic [1:0][4:0]   raddr;
    logic [1:0]        rvalid;
    logic [1:0][31:0]  rdata;
    logic [1:0]        wen;
    logic [1:0][4:0]   waddr;
    logic [1:0][31:0]  wdata;
    logic              wr_collision;
    logic              wr_oob;

    int n_cmp;
    int n_err;

    typedef struct {
        logic        rst;
        logic [1:0]  ren;
        logic [4:0]  ra0, ra1;
        logic [1:0]  wen;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [1:0]  rv;
        logic [31:0] rd0, rd1;
        logic        coll, oob;
    } vec_t;

    vec_t tv [20];

    regfile_mport_sync_rst #(
        .WIDTH     (32),
        .N_REG     (20),
        .N_RPORTS  (2),
        .N_WPORTS  (2),
        .ZERO_REG0 (1),
        .RST_VAL   (32'hA5A5_A5A5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ren          (ren),
        .raddr        (raddr),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .wen          (wen),
        .waddr        (waddr),
        .wdata        (wdata),
        .wr_collision (wr_collision),
        .wr_oob       (wr_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                                input logic [1:0] we, input logic [4:0] w0, input logic [4:0] w1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] v, input logic [31:0] q0, input logic [31:0] q1,
                                input logic c, input logic o);
        vec_t t;
        t.rst = r;  t.ren = re; t.ra0 = a0; t.ra1 = a1;
        t.wen = we; t.wa0 = w0; t.wa1 = w1; t.wd0 = d0; t.wd1 = d1;
        t.rv = v;   t.rd0 = q0; t.rd1 = q1; t.coll = c; t.oob = o;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [1:0] we, input logic [4:0] w0, input logic [4:0] w1,
                         input logic [31:0] d0, input logic [31:0] d1);
        rst = r; ren = re; raddr[0] = a0; raddr[1] = a1;
        wen = we; waddr[0] = w0; waddr[1] = w1; wdata[0] = d0; wdata[1] = d1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; ren = 2'b00; raddr = '{5'd0, 5'd0};
        wen = 2'b00; waddr = '{5'd0, 5'd0}; wdata = '{32'h0, 32'h0};

        //           rst   ren    ra0    ra1    wen    wa0     wa1    wd0           wd1           rv     rd0           rd1           coll  oob
        tv[0]  = mk(1'b1, 2'b11, 5'd5,  5'd5,  2'b11, 5'd3,  5'd3,  32'h1,        32'h2,        2'b00, 32'h0,        32'h0,        1'b0, 1'b0);
        tv[1]  = mk(1'b0, 2'b11, 5'd5,  5'd0,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b11, RV,           32'h0,        1'b0, 1'b0);
        tv[2]  = mk(1'b0, 2'b00, 5'd0,  5'd0,  2'b01, 5'd3,  5'd0,  32'h1234,     32'h0,        2'b00, RV,           32'h0,        1'b0, 1'b0);
        tv[3]  = mk(1'b0, 2'b10, 5'd0,  5'd3,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b10, RV,           32'h1234,     1'b0, 1'b0);
        tv[4]  = mk(1'b0, 2'b00, 5'd0,  5'd0,  2'b11, 5'd7,  5'd7,  32'h11,       32'h22,       2'b00, RV,           32'h1234,     1'b1, 1'b0);
        tv[5]  = mk(1'b0, 2'b01, 5'd7,  5'd0,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b01, 32'h22,       32'h1234,     1'b0, 1'b0);
        tv[6]  = mk(1'b0, 2'b00, 5'd0,  5'd0,  2'b01, 5'd4,  5'd0,  32'h0,        32'h0,        2'b00, 32'h22,       32'h1234,     1'b0, 1'b0);
        tv[7]  = mk(1'b0, 2'b01, 5'd4,  5'd0,  2'b10, 5'd0,  5'd4,  32'h0,        32'hBEEF,     2'b01, BYP,          32'h1234,     1'b0, 1'b0);
        tv[8]  = mk(1'b0, 2'b10, 5'd0,  5'd4,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b10, BYP,          32'hBEEF,     1'b0, 1'b0);
        tv[9]  = mk(1'b0, 2'b01, 5'd0,  5'd0,  2'b01, 5'd0,  5'd0,  32'hFFFF,     32'h0,        2'b01, 32'h0,        32'hBEEF,     1'b0, 1'b0);
        tv[10] = mk(1'b0, 2'b01, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b01, 32'h0,        32'hBEEF,     1'b0, 1'b0);
        tv[11] = mk(1'b0, 2'b00, 5'd0,  5'd0,  2'b01, 5'd25, 5'd0,  32'h5555,     32'h0,        2'b00, 32'h0,        32'hBEEF,     1'b0, 1'b1);
        tv[12] = mk(1'b0, 2'b11, 5'd25, 5'd9,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b11, 32'h0,        RV,           1'b0, 1'b1);
        tv[13] = mk(1'b0, 2'b00, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0,        RV,           1'b0, 1'b0);
        tv[14] = mk(1'b0, 2'b00, 5'd0,  5'd0,  2'b11, 5'd8,  5'd9,  32'h88,       32'h99,       2'b00, 32'h0,        RV,           1'b0, 1'b0);
        tv[15] = mk(1'b0, 2'b11, 5'd8,  5'd9,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b11, 32'h88,       32'h99,       1'b0, 1'b0);
        tv[16] = mk(1'b0, 2'b00, 5'd0,  5'd0,  2'b11, 5'd10, 5'd25, 32'hA0,       32'h77,       2'b00, 32'h88,       32'h99,       1'b0, 1'b1);
        tv[17] = mk(1'b0, 2'b01, 5'd10, 5'd0,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b01, 32'hA0,       32'h99,       1'b0, 1'b0);
        tv[18] = mk(1'b1, 2'b11, 5'd3,  5'd7,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        1'b0, 1'b0);
        tv[19] = mk(1'b0, 2'b11, 5'd3,  5'd7,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b11, RV,           RV,           1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            drive(tv[i].rst, tv[i].ren, tv[i].ra0, tv[i].ra1, tv[i].wen, tv[i].wa0, tv[i].wa1, tv[i].wd0, tv[i].wd1);
            chk("rvalid",       i, {30'd0, rvalid},       {30'd0, tv[i].rv});
            chk("rdata0",       i, rdata[0],              tv[i].rd0);
            chk("rdata1",       i, rdata[1],              tv[i].rd1);
            chk("wr_collision", i, {31'd0, wr_collision}, {31'd0, tv[i].coll});
            chk("wr_oob",       i, {31'd0, wr_oob},       {31'd0, tv[i].oob});
        end

        // Back-to-back collisions keep the flag high, then it drops; last winner persists.
        drive(1'b0, 2'b00, 5'd0, 5'd0, 2'b11, 5'd6, 5'd6, 32'h1, 32'h2);
        chk("coll_seq_a", 0, {31'd0, wr_collision}, 32'h1);
        drive(1'b0, 2'b00, 5'd0, 5'd0, 2'b11, 5'd6, 5'd6, 32'h3, 32'h4);
        chk("coll_seq_b", 1, {31'd0, wr_collision}, 32'h1);
        drive(1'b0, 2'b01, 5'd6, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        chk("coll_seq_c", 2, {31'd0, wr_collision}, 32'h0);
        chk("coll_seq_rd", 3, rdata[0], 32'h4);
        chk("coll_seq_rv", 4, {30'd0, rvalid}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
